// File: rtl/tft_rx_monitor.sv
// ---------------------------------------------------------------------------
// tft_rx_monitor
//
// Purpose
//   Passive monitor for a DE-only parallel RGB (TFT) video stream. It locks
//   onto the stream by finding the vertical blanking gap. A gap is a run of
//   VGAP consecutive data-enable-low cycles. Once locked, the monitor:
//     - re-emits every received pixel with its (x, y) coordinate and a
//       3-3-3 bit colour reduction, one cycle after the pixel is sampled;
//     - measures each line length and the frame height, and flags frames
//       whose geometry differs from X_RES x Y_RES;
//     - captures the pixel that appears at a programmable probe coordinate;
//     - counts completed frames.
//
// Parameters
//   X_RES  expected active pixels per line
//   Y_RES  expected active lines per frame
//   VGAP   consecutive DE-low cycles that mark vertical blanking (>= 2)
//
// Ports
//   tft_clk        in   pixel clock; everything runs on its rising edge
//   rstb           in   asynchronous, active-high reset
//   tft_data_ena   in   data enable of the incoming stream
//   tft_red/green/blue in 8b pixel components
//   probe_x/probe_y in  10b/9b coordinate to capture
//   x / y          out  10b/9b coordinate of the pixel shown on pix_rgb
//   pix_valid      out  pix_rgb, x and y are valid this cycle
//   pix_rgb        out  {red[7:5], green[7:5], blue[7:5]}
//   line_width     out  last measured line length
//   frame_lines    out  last measured frame height
//   probe_rgb      out  colour captured at the probe coordinate
//   probe_valid    out  sticky: a probe capture has happened since reset
//   frame_done     out  one-cycle pulse at the end of each frame
//   err_width      out  some line of the last frame was not X_RES long
//   err_height     out  the last frame did not have Y_RES lines
//   frame_count    out  completed frames since reset (wraps)
// ---------------------------------------------------------------------------
module tft_rx_monitor #(
  parameter int X_RES = 480,
  parameter int Y_RES = 272,
  parameter int VGAP  = 1000
) (
  input  logic        tft_clk,
  input  logic        rstb,
  input  logic        tft_data_ena,
  input  logic [7:0]  tft_red,
  input  logic [7:0]  tft_green,
  input  logic [7:0]  tft_blue,
  input  logic [9:0]  probe_x,
  input  logic [8:0]  probe_y,
  output logic [9:0]  x,
  output logic [8:0]  y,
  output logic        pix_valid,
  output logic [8:0]  pix_rgb,
  output logic [9:0]  line_width,
  output logic [8:0]  frame_lines,
  output logic [8:0]  probe_rgb,
  output logic        probe_valid,
  output logic        frame_done,
  output logic        err_width,
  output logic        err_height,
  output logic [15:0] frame_count
);

  // The gap counter only needs to hold 0..VGAP because it saturates there.
  localparam int               GAP_W    = $clog2(VGAP + 1);
  localparam logic [GAP_W-1:0] VGAP_C   = GAP_W'(VGAP);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [9:0]       X_RES_C  = 10'(X_RES);
  localparam logic [8:0]       Y_RES_C  = 9'(Y_RES);
  localparam logic [9:0]       PIX_MAX  = 10'd1023;
  localparam logic [8:0]       LINE_MAX = 9'd511;

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,  // hunting for the first vertical gap, data ignored
    ST_VBLANK = 2'd1,  // locked, waiting for the first line of a frame
    ST_ACTIVE = 2'd2,  // receiving pixels of a line
    ST_HBLANK = 2'd3   // between lines, or sliding into vertical blanking
  } state_t;

  state_t state_q, state_d;

  // Measurement state
  logic [GAP_W-1:0] gap_q, gap_d;            // consecutive DE-low cycles
  logic [9:0]       pix_cnt_q, pix_cnt_d;    // pixels seen in current line
  logic [8:0]       line_cnt_q, line_cnt_d;  // lines seen in current frame
  logic             werr_q, werr_d;          // width error seen this frame

  // Output registers
  logic [9:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic        pix_valid_q, pix_valid_d;
  logic [8:0]  pix_rgb_q, pix_rgb_d;
  logic [9:0]  line_width_q, line_width_d;
  logic [8:0]  frame_lines_q, frame_lines_d;
  logic [8:0]  probe_rgb_q, probe_rgb_d;
  logic        probe_valid_q, probe_valid_d;
  logic        frame_done_q, frame_done_d;
  logic        err_width_q, err_width_d;
  logic        err_height_q, err_height_d;
  logic [15:0] frame_count_q, frame_count_d;

  // Helper values shared by several states
  logic [8:0]       rgb_in;
  logic [GAP_W-1:0] gap_inc;
  logic [9:0]       pix_inc;
  logic [8:0]       line_inc;
  logic             probe_hit;

  // Only the top three bits of each component are forwarded.
  assign rgb_in   = {tft_red[7:5], tft_green[7:5], tft_blue[7:5]};

  // The lower colour bits are intentionally dropped.
  logic unused_color_bits;
  assign unused_color_bits = ^{tft_red[4:0], tft_green[4:0], tft_blue[4:0]};

  // Saturating increments.
  assign gap_inc  = (gap_q == VGAP_C)        ? gap_q      : gap_q + GAP_ONE;
  assign pix_inc  = (pix_cnt_q == PIX_MAX)   ? pix_cnt_q  : pix_cnt_q + 10'd1;
  assign line_inc = (line_cnt_q == LINE_MAX) ? line_cnt_q : line_cnt_q + 9'd1;

  // The probe looks at the registered pixel stage. It uses the probe
  // coordinate present in the same cycle that pixel is presented, so the
  // capture lands one cycle after pix_valid.
  assign probe_hit = pix_valid_q && (x_q == probe_x) && (y_q == probe_y);

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    gap_d         = gap_q;
    pix_cnt_d     = pix_cnt_q;
    line_cnt_d    = line_cnt_q;
    werr_d        = werr_q;
    x_d           = x_q;
    y_d           = y_q;
    pix_valid_d   = 1'b0;
    pix_rgb_d     = pix_rgb_q;
    line_width_d  = line_width_q;
    frame_lines_d = frame_lines_q;
    frame_done_d  = 1'b0;
    err_width_d   = err_width_q;
    err_height_d  = err_height_q;
    frame_count_d = frame_count_q;
    probe_rgb_d   = probe_hit ? pix_rgb_q : probe_rgb_q;
    probe_valid_d = probe_valid_q | probe_hit;

    unique case (state_q)
      ST_SYNC: begin
        // Only the length of the DE-low run matters here. Lines seen before
        // lock have unknown position in the frame and are discarded.
        if (tft_data_ena) begin
          gap_d = '0;
        end else begin
          gap_d = gap_inc;
          if (gap_inc == VGAP_C) begin
            state_d = ST_VBLANK;
          end
        end
      end

      ST_VBLANK: begin
        if (tft_data_ena) begin
          // First pixel of a frame. It is emitted as (0,0), and the pixel
          // counter already includes it.
          state_d     = ST_ACTIVE;
          gap_d       = '0;
          line_cnt_d  = '0;
          pix_cnt_d   = 10'd1;
          pix_valid_d = 1'b1;
          x_d         = '0;
          y_d         = '0;
          pix_rgb_d   = rgb_in;
        end
      end

      ST_ACTIVE: begin
        if (tft_data_ena) begin
          pix_valid_d = 1'b1;
          x_d         = pix_cnt_q;
          y_d         = line_cnt_q;
          pix_rgb_d   = rgb_in;
          pix_cnt_d   = pix_inc;
        end else begin
          // The falling edge of DE closes the line. This low cycle is the
          // first cycle of the gap, so the gap counter starts at 1.
          state_d      = ST_HBLANK;
          line_width_d = pix_cnt_q;
          if (pix_cnt_q != X_RES_C) begin
            werr_d = 1'b1;
          end
          line_cnt_d = line_inc;
          gap_d      = GAP_ONE;
        end
      end

      ST_HBLANK: begin
        // DE high always wins. A line that starts on the same cycle the gap
        // would have reached VGAP is still part of the current frame.
        if (tft_data_ena) begin
          state_d     = ST_ACTIVE;
          gap_d       = '0;
          pix_cnt_d   = 10'd1;
          pix_valid_d = 1'b1;
          x_d         = '0;
          y_d         = line_cnt_q;
          pix_rgb_d   = rgb_in;
        end else begin
          gap_d = gap_inc;
          if (gap_inc == VGAP_C) begin
            // The gap is long enough to be vertical blanking: close the frame.
            state_d       = ST_VBLANK;
            frame_done_d  = 1'b1;
            frame_lines_d = line_cnt_q;
            err_height_d  = (line_cnt_q != Y_RES_C);
            err_width_d   = werr_q;
            frame_count_d = frame_count_q + 16'd1;
            werr_d        = 1'b0;
            line_cnt_d    = '0;
          end
        end
      end

      default: begin
        state_d = ST_SYNC;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State register. Reset drops all partial measurements and returns to
  // SYNC, so the monitor must see a full gap again before it trusts data.
  // -------------------------------------------------------------------------
  always_ff @(posedge tft_clk or posedge rstb) begin
    if (rstb) begin
      state_q       <= ST_SYNC;
      gap_q         <= '0;
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
      werr_q        <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      pix_valid_q   <= 1'b0;
      pix_rgb_q     <= '0;
      line_width_q  <= '0;
      frame_lines_q <= '0;
      probe_rgb_q   <= '0;
      probe_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      err_width_q   <= 1'b0;
      err_height_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      gap_q         <= gap_d;
      pix_cnt_q     <= pix_cnt_d;
      line_cnt_q    <= line_cnt_d;
      werr_q        <= werr_d;
      x_q           <= x_d;
      y_q           <= y_d;
      pix_valid_q   <= pix_valid_d;
      pix_rgb_q     <= pix_rgb_d;
      line_width_q  <= line_width_d;
      frame_lines_q <= frame_lines_d;
      probe_rgb_q   <= probe_rgb_d;
      probe_valid_q <= probe_valid_d;
      frame_done_q  <= frame_done_d;
      err_width_q   <= err_width_d;
      err_height_q  <= err_height_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign pix_valid   = pix_valid_q;
  assign pix_rgb     = pix_rgb_q;
  assign line_width  = line_width_q;
  assign frame_lines = frame_lines_q;
  assign probe_rgb   = probe_rgb_q;
  assign probe_valid = probe_valid_q;
  assign frame_done  = frame_done_q;
  assign err_width   = err_width_q;
  assign err_height  = err_height_q;
  assign frame_count = frame_count_q;

endmodule
